mmu_feeder: RTL and testbench
=============================

Name: mmu_feeder

Overview:
Initiator-side sequencer that drives the systolic MMU's control, wt_arr and data_arr inputs.
- Buffers one DEPTH×DEPTH weight tile, then shifts it into the array with control held high for exactly DEPTH contiguous cycles.
- Streams activation vectors through per-lane diagonal skew registers, then drains the skew.
- Sits between the tile/activation source (valid/ready) and the MMU.

Parameters:
DEPTH, 4, array dimension (lanes per vector, weight rows per tile)
BIT_WIDTH, 8, element width in bits

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  begin a tile job; sampled in IDLE only
reuse_wt  in  1  sampled with start; 1 = skip weight load, keep weights resident in the array
wt_valid  in  1  weight row valid
wt_ready  out  1  feeder accepts a weight row
wt_row  in  DEPTH*BIT_WIDTH  weight row; element j at bits [j*BIT_WIDTH +: BIT_WIDTH]
act_valid  in  1  activation vector valid
act_ready  out  1  feeder accepts an activation vector
act_vec  in  DEPTH*BIT_WIDTH  activation vector; lane i at bits [i*BIT_WIDTH +: BIT_WIDTH]
act_last  in  1  qualifies the final vector of the job
control  out  1  to MMU; 1 = weight shift cycle
wt_arr  out  DEPTH*BIT_WIDTH  to MMU weight input
data_arr  out  DEPTH*BIT_WIDTH  to MMU skewed activation input
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at job completion

Behaviour:
- Reset (async, any time, mid-job included) forces:
  - state IDLE; all outputs 0.
  - weight buffer, fill/emit counters and every skew register cleared.
- control, wt_arr, data_arr, done are registered outputs. wt_ready and act_ready are combinational from state only.
- Handshake: transfer occurs when valid && ready on a rising edge. Ready never depends on valid.
- IDLE:
  - start=1, reuse_wt=0 -> WT_FILL.
  - start=1, reuse_wt=1 -> STREAM.
  - start is ignored in every other state.
- WT_FILL:
  - wt_ready=1; each accepted row is written to buffer slot fill_cnt, and fill_cnt increments.
  - Gaps in wt_valid are allowed.
  - On acceptance of row DEPTH-1 -> WT_EMIT. wt_ready drops the following cycle.
- WT_EMIT: exactly DEPTH consecutive cycles.
  - Cycle k: control=1, wt_arr=buffer[DEPTH-1-k], data_arr=0. Reverse order, so row 0 lands in array row 0 after the shift.
  - After the DEPTH-th cycle -> STREAM.
  - control is never high outside WT_EMIT.
- STREAM:
  - act_ready=1, control=0, wt_arr=0.
  - Each cycle, skew lane i input is act_vec lane i if a transfer occurs, else 0 (bubble).
  - Lane i output is delayed i cycles (lane 0 is 1 register, lane i is i+1 registers); data_arr lane i is the skew output.
  - Latency: vector accepted at edge t produces lane 0 at data_arr after edge t and lane i after edge t+i.
  - act_last is honoured only with a transfer -> FLUSH.
- FLUSH:
  - act_ready=0; zeros enter the skew for DEPTH-1 cycles, so the last vector's lane DEPTH-1 is emitted.
  - Then done=1 for one cycle and -> IDLE.
  - data_arr is 0 in the cycle after done.
- Boundaries:
  - wt_valid outside WT_FILL and act_valid outside STREAM are ignored; no state change, no data loss claims.
  - act_last on the first vector is legal: one vector plus flush.
  - reuse_wt=1 with no prior load streams against whatever the array holds; the feeder does not check this.
  - DEPTH=1: skew is a single register; FLUSH is 0 cycles, so done follows the last transfer directly.
- Width: pure data movement, no arithmetic. Counters are $clog2(DEPTH)+1 bits.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, WT_FILL, WT_EMIT, STREAM, FLUSH);
  - the DEPTH/BIT_WIDTH defaults, common with the MMU;
  - the lane-slice helper constant.
- One sub-module: mmu_skew_lane (parameter DELAY, BIT_WIDTH, async-reset shift register), instantiated DEPTH times in a generate loop.

Test Plan:
- Reset mid-WT_EMIT (cycle 2) -> control=0, busy=0, data_arr=0 immediately. A restart with rows 0x04030201.. reloads cleanly, with no stale row emitted.
- start, reuse_wt=0, rows R0=0x03020100, R1=0x07060504, R2=0x0B0A0908, R3=0x0F0E0D0C with one-cycle wt_valid gaps:
  - control=1 for exactly 4 consecutive cycles;
  - wt_arr sequence R3, R2, R1, R0;
  - data_arr=0 throughout.
- Stream act_vec 0x44332211 then 0x88776655(last), back-to-back:
  - data_arr lane 0 = 0x11, 0x55 on consecutive cycles;
  - lane 3 = 0x44 three cycles after lane 0's 0x11;
  - done pulses exactly once after 3 flush cycles.
- act_valid bubble between two vectors -> zero column inserted in every lane at the matching skewed position; act_ready stays 1.
- start with reuse_wt=1 -> wt_ready never asserts, control never asserts, act_ready=1 on the cycle after start.
- start and wt_valid asserted while busy -> ignored; the job completes with a single done, and the tile counter in the bench is unchanged.

Source files
------------

// File: rtl/mmu_feeder_pkg.sv
// Shared definitions for the MMU feeder and the systolic array it drives.
// Holds the feeder state encoding, the array geometry defaults and the
// helper that locates a lane/element inside a packed row vector.
package mmu_feeder_pkg;

  localparam int MMU_DEPTH     = 4;
  localparam int MMU_BIT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    WT_FILL,
    WT_EMIT,
    STREAM,
    FLUSH
  } feeder_state_e;

  // Low bit of lane/element `lane` in a packed vector of `bw`-bit elements.
  function automatic int lane_lo(input int lane, input int bw);
    return lane * bw;
  endfunction

endpackage

// File: rtl/mmu_skew_lane.sv
// One lane of the activation skew: a DELAY-stage shift register.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (clears every stage)
//   din_i     - lane input (zero when no activation is transferred)
//   dout_o    - output of the last stage, DELAY cycles after din_i
module mmu_skew_lane #(
  parameter int DELAY     = 1,
  parameter int BIT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] din_i,
  output logic [BIT_WIDTH-1:0] dout_o
);

  logic [BIT_WIDTH-1:0] sr_q [DELAY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DELAY; k++) sr_q[k] <= '0;
    end else begin
      sr_q[0] <= din_i;
      for (int k = 1; k < DELAY; k++) sr_q[k] <= sr_q[k-1];
    end
  end

  assign dout_o = sr_q[DELAY-1];

endmodule

// File: rtl/mmu_feeder.sv
// Initiator-side sequencer for the systolic MMU.
// Buffers a DEPTH x DEPTH weight tile, shifts it into the array (control
// high for exactly DEPTH cycles, rows in reverse order), then streams
// activation vectors through per-lane diagonal skew registers and drains
// the skew before pulsing done.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   start, reuse_wt   - job request (IDLE only); reuse_wt skips the weight load
//   wt_valid/wt_ready/wt_row              - weight row handshake
//   act_valid/act_ready/act_vec/act_last  - activation vector handshake
//   control, wt_arr, data_arr             - registered drive of the MMU
//   busy              - not IDLE
//   done              - one-cycle pulse at job completion
module mmu_feeder
  import mmu_feeder_pkg::*;
#(
  parameter int DEPTH     = MMU_DEPTH,
  parameter int BIT_WIDTH = MMU_BIT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       reuse_wt,
  input  logic                       wt_valid,
  output logic                       wt_ready,
  input  logic [DEPTH*BIT_WIDTH-1:0] wt_row,
  input  logic                       act_valid,
  output logic                       act_ready,
  input  logic [DEPTH*BIT_WIDTH-1:0] act_vec,
  input  logic                       act_last,
  output logic                       control,
  output logic [DEPTH*BIT_WIDTH-1:0] wt_arr,
  output logic [DEPTH*BIT_WIDTH-1:0] data_arr,
  output logic                       busy,
  output logic                       done
);

  localparam int ROW_W = DEPTH * BIT_WIDTH;
  localparam int CW    = $clog2(DEPTH) + 1;

  feeder_state_e    state_q, state_d;
  logic [CW-1:0]    fill_cnt_q, fill_cnt_d;
  // Counts emitted rows in WT_EMIT and elapsed flush cycles in FLUSH.
  logic [CW-1:0]    emit_cnt_q, emit_cnt_d;
  logic [ROW_W-1:0] buf_q [DEPTH];
  logic [ROW_W-1:0] buf_d [DEPTH];
  logic             control_q, control_d;
  logic [ROW_W-1:0] wt_arr_q, wt_arr_d;
  logic             done_q, done_d;
  logic [ROW_W-1:0] emit_row;
  logic             act_xfer;

  assign wt_ready  = (state_q == WT_FILL);
  assign act_ready = (state_q == STREAM);
  assign busy      = (state_q != IDLE);
  assign act_xfer  = act_valid && act_ready;

  // Row shown during the next emit cycle: emit_cnt_q rows are already out,
  // and rows leave highest-index first.
  always_comb begin
    emit_row = '0;
    for (int r = 0; r < DEPTH; r++) begin
      if (emit_cnt_q == CW'(r)) emit_row = buf_q[DEPTH-1-r];
    end
  end

  // Outputs are registered, so they are computed from the state being
  // entered: control rises on the edge that accepts the last weight row.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    emit_cnt_d = emit_cnt_q;
    buf_d      = buf_q;
    control_d  = 1'b0;
    wt_arr_d   = '0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          fill_cnt_d = '0;
          emit_cnt_d = '0;
          state_d    = reuse_wt ? STREAM : WT_FILL;
        end
      end
      WT_FILL: begin
        if (wt_valid) begin
          for (int r = 0; r < DEPTH; r++) begin
            if (fill_cnt_q == CW'(r)) buf_d[r] = wt_row;
          end
          fill_cnt_d = fill_cnt_q + CW'(1);
          if (fill_cnt_q == CW'(DEPTH-1)) begin
            // The row being accepted is the first one emitted.
            state_d    = WT_EMIT;
            emit_cnt_d = CW'(1);
            control_d  = 1'b1;
            wt_arr_d   = wt_row;
          end
        end
      end
      WT_EMIT: begin
        if (emit_cnt_q == CW'(DEPTH)) begin
          state_d    = STREAM;
          emit_cnt_d = '0;
        end else begin
          control_d  = 1'b1;
          wt_arr_d   = emit_row;
          emit_cnt_d = emit_cnt_q + CW'(1);
        end
      end
      STREAM: begin
        if (act_xfer && act_last) begin
          if (DEPTH == 1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d    = FLUSH;
            emit_cnt_d = CW'(1);
          end
        end
      end
      FLUSH: begin
        if (emit_cnt_q == CW'(DEPTH-1)) begin
          state_d    = IDLE;
          emit_cnt_d = '0;
          done_d     = 1'b1;
        end else begin
          emit_cnt_d = emit_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fill_cnt_q <= '0;
      emit_cnt_q <= '0;
      control_q  <= 1'b0;
      wt_arr_q   <= '0;
      done_q     <= 1'b0;
      for (int r = 0; r < DEPTH; r++) buf_q[r] <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      emit_cnt_q <= emit_cnt_d;
      control_q  <= control_d;
      wt_arr_q   <= wt_arr_d;
      done_q     <= done_d;
      buf_q      <= buf_d;
    end
  end

  assign control = control_q;
  assign wt_arr  = wt_arr_q;
  assign done    = done_q;

  // Lane i holds i+1 registers; a bubble or non-STREAM cycle feeds zeros.
  for (genvar i = 0; i < DEPTH; i++) begin : g_lane
    logic [BIT_WIDTH-1:0] lane_in;
    assign lane_in = act_xfer ? act_vec[lane_lo(i, BIT_WIDTH) +: BIT_WIDTH] : '0;
    mmu_skew_lane #(
      .DELAY    (i + 1),
      .BIT_WIDTH(BIT_WIDTH)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .din_i (lane_in),
      .dout_o(data_arr[lane_lo(i, BIT_WIDTH) +: BIT_WIDTH])
    );
  end

endmodule

// File: tb/tb_mmu_feeder.sv
// Scoreboard bench for mmu_feeder (DEPTH=4, BIT_WIDTH=8).
// Stimulus pushes the expected post-edge output record into a queue; the
// monitor pops and compares one record per falling edge.
module tb_mmu_feeder;

  localparam int DEPTH = 4;
  localparam int BW    = 8;
  localparam int RW    = DEPTH * BW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, reuse_wt;
  logic          wt_valid, wt_ready;
  logic [RW-1:0] wt_row;
  logic          act_valid, act_ready, act_last;
  logic [RW-1:0] act_vec;
  logic          control, busy, done;
  logic [RW-1:0] wt_arr, data_arr;

  always #5 clk = ~clk;

  mmu_feeder #(.DEPTH(DEPTH), .BIT_WIDTH(BW)) dut (
    .clk(clk), .rst(rst), .start(start), .reuse_wt(reuse_wt),
    .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_row(wt_row),
    .act_valid(act_valid), .act_ready(act_ready), .act_vec(act_vec),
    .act_last(act_last), .control(control), .wt_arr(wt_arr),
    .data_arr(data_arr), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic          busy;
    logic          wr;
    logic          ar;
    logic          ctl;
    logic          dn;
    logic [RW-1:0] wt;
    logic [RW-1:0] dat;
  } exp_t;

  exp_t  exp_q [$];
  string tag_q [$];
  int    checks = 0;
  int    errors = 0;
  int    done_seen = 0;
  int    ctl_seen = 0;

  function automatic exp_t mk(input logic b, input logic wr, input logic ar,
                              input logic c, input logic d,
                              input logic [RW-1:0] w, input logic [RW-1:0] dt);
    exp_t e;
    e = '{busy: b, wr: wr, ar: ar, ctl: c, dn: d, wt: w, dat: dt};
    return e;
  endfunction

  task automatic expect_now(input string tag, input exp_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic tick(input string tag, input exp_t e);
    @(posedge clk);
    #1;
    expect_now(tag, e);
  endtask

  // Monitor: one popped expectation per falling edge.
  always @(negedge clk) begin
    exp_t  e, a;
    string t;
    if (control) ctl_seen++;
    if (done) done_seen++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = mk(busy, wt_ready, act_ready, control, done, wt_arr, data_arr);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got busy=%b wr=%b ar=%b ctl=%b done=%b wt=%h data=%h, want busy=%b wr=%b ar=%b ctl=%b done=%b wt=%h data=%h",
                 t, a.busy, a.wr, a.ar, a.ctl, a.dn, a.wt, a.dat,
                 e.busy, e.wr, e.ar, e.ctl, e.dn, e.wt, e.dat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  logic [RW-1:0] rows [4];
  exp_t Z;

  initial begin
    Z = mk(0, 0, 0, 0, 0, '0, '0);
    rst = 1'b1; start = 0; reuse_wt = 0; wt_valid = 0; wt_row = '0;
    act_valid = 0; act_vec = '0; act_last = 0;
    repeat (2) @(posedge clk);
    #1;
    expect_now("reset_state", Z);
    @(negedge clk); #1;
    rst = 1'b0;

    // ---- Full load with gaps, then two back-to-back vectors ----
    rows[0] = 32'h03020100; rows[1] = 32'h07060504;
    rows[2] = 32'h0B0A0908; rows[3] = 32'h0F0E0D0C;
    start = 1; reuse_wt = 0;
    tick("start_fill", mk(1, 1, 0, 0, 0, '0, '0));
    start = 0;
    for (int r = 0; r < 4; r++) begin
      wt_valid = 1; wt_row = rows[r];
      if (r < 3) begin
        tick("fill_row", mk(1, 1, 0, 0, 0, '0, '0));
        wt_valid = 0; wt_row = 32'hDEADBEEF;
        tick("fill_gap", mk(1, 1, 0, 0, 0, '0, '0));
      end else begin
        tick("emit_r3", mk(1, 0, 0, 1, 0, rows[3], '0));
      end
    end
    wt_valid = 0;
    tick("emit_r2", mk(1, 0, 0, 1, 0, rows[2], '0));
    tick("emit_r1", mk(1, 0, 0, 1, 0, rows[1], '0));
    tick("emit_r0", mk(1, 0, 0, 1, 0, rows[0], '0));
    tick("stream_enter", mk(1, 0, 1, 0, 0, '0, '0));
    act_valid = 1; act_vec = 32'h44332211; act_last = 0;
    tick("skew_a0", mk(1, 0, 1, 0, 0, '0, 32'h00000011));
    act_vec = 32'h88776655; act_last = 1;
    tick("skew_a1", mk(1, 0, 0, 0, 0, '0, 32'h00002255));
    act_valid = 0; act_last = 0; act_vec = '0;
    tick("flush_a1", mk(1, 0, 0, 0, 0, '0, 32'h00336600));
    tick("flush_a2", mk(1, 0, 0, 0, 0, '0, 32'h44770000));
    tick("done_a",   mk(0, 0, 0, 0, 1, '0, 32'h88000000));
    tick("after_done_a", Z);

    // ---- Reuse weights, bubble between vectors, stray wt_valid ----
    start = 1; reuse_wt = 1; wt_valid = 1; wt_row = 32'hCAFEF00D;
    tick("reuse_start", mk(1, 0, 1, 0, 0, '0, '0));
    start = 0; reuse_wt = 0;
    act_valid = 1; act_vec = 32'h04030201;
    tick("skew_b0", mk(1, 0, 1, 0, 0, '0, 32'h00000001));
    act_valid = 0; act_vec = 32'hFFFFFFFF;
    tick("bubble", mk(1, 0, 1, 0, 0, '0, 32'h00000200));
    act_valid = 1; act_vec = 32'h08070605; act_last = 1;
    tick("skew_b2", mk(1, 0, 0, 0, 0, '0, 32'h00030005));
    act_valid = 0; act_last = 0; act_vec = '0;
    tick("flush_b1", mk(1, 0, 0, 0, 0, '0, 32'h04000600));
    tick("flush_b2", mk(1, 0, 0, 0, 0, '0, 32'h00070000));
    tick("done_b",   mk(0, 0, 0, 0, 1, '0, 32'h08000000));
    wt_valid = 0;
    tick("after_done_b", Z);

    // ---- start and wt_valid held high while busy; single-vector job ----
    start = 1; reuse_wt = 1;
    tick("reuse_start2", mk(1, 0, 1, 0, 0, '0, '0));
    reuse_wt = 0; wt_valid = 1;
    act_valid = 1; act_vec = 32'h0D0C0B0A; act_last = 1;
    tick("single_vec", mk(1, 0, 0, 0, 0, '0, 32'h0000000A));
    act_valid = 0; act_last = 0; act_vec = '0;
    tick("busy_ignore1", mk(1, 0, 0, 0, 0, '0, 32'h00000B00));
    tick("busy_ignore2", mk(1, 0, 0, 0, 0, '0, 32'h000C0000));
    tick("done_c", mk(0, 0, 0, 0, 1, '0, 32'h0D000000));
    start = 0; wt_valid = 0;
    tick("after_done_c", Z);
    @(negedge clk); #1;
    checks++;
    if (done_seen != 3) begin
      errors++;
      $display("FAIL done_count: got %0d, want 3", done_seen);
    end
    checks++;
    if (ctl_seen != 4) begin
      errors++;
      $display("FAIL tile_count: control cycles %0d, want 4", ctl_seen);
    end

    // ---- Reset during WT_EMIT cycle 2, then clean reload ----
    start = 1; reuse_wt = 0;
    tick("start_fill2", mk(1, 1, 0, 0, 0, '0, '0));
    start = 0;
    wt_valid = 1; wt_row = 32'h11111111;
    tick("fill_u0", mk(1, 1, 0, 0, 0, '0, '0));
    wt_row = 32'h22222222;
    tick("fill_u1", mk(1, 1, 0, 0, 0, '0, '0));
    wt_row = 32'h33333333;
    tick("fill_u2", mk(1, 1, 0, 0, 0, '0, '0));
    wt_row = 32'h44444444;
    tick("emit_u3", mk(1, 0, 0, 1, 0, 32'h44444444, '0));
    wt_valid = 0; wt_row = '0;
    tick("emit_u2", mk(1, 0, 0, 1, 0, 32'h33333333, '0));
    @(posedge clk); #1;
    rst = 1'b1;
    expect_now("rst_async", Z);
    tick("rst_hold", Z);
    rst = 1'b0;

    rows[0] = 32'h04030201; rows[1] = 32'h08070605;
    rows[2] = 32'h0C0B0A09; rows[3] = 32'h100F0E0D;
    start = 1; reuse_wt = 0;
    tick("restart_fill", mk(1, 1, 0, 0, 0, '0, '0));
    start = 0;
    for (int r = 0; r < 4; r++) begin
      wt_valid = 1; wt_row = rows[r];
      if (r < 3) tick("refill_row", mk(1, 1, 0, 0, 0, '0, '0));
      else       tick("reemit_r3", mk(1, 0, 0, 1, 0, rows[3], '0));
    end
    wt_valid = 0; wt_row = '0;
    tick("reemit_r2", mk(1, 0, 0, 1, 0, rows[2], '0));
    tick("reemit_r1", mk(1, 0, 0, 1, 0, rows[1], '0));
    tick("reemit_r0", mk(1, 0, 0, 1, 0, rows[0], '0));
    tick("restream", mk(1, 0, 1, 0, 0, '0, '0));
    act_valid = 1; act_vec = 32'hA4A3A2A1; act_last = 1;
    tick("re_vec", mk(1, 0, 0, 0, 0, '0, 32'h000000A1));
    act_valid = 0; act_last = 0; act_vec = '0;
    tick("re_flush1", mk(1, 0, 0, 0, 0, '0, 32'h0000A200));
    tick("re_flush2", mk(1, 0, 0, 0, 0, '0, 32'h00A30000));
    tick("re_done",   mk(0, 0, 0, 0, 1, '0, 32'hA4000000));
    tick("re_after",  Z);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    checks++;
    if (done_seen != 4) begin
      errors++;
      $display("FAIL done_total: got %0d, want 4", done_seen);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
